// File: rtl/motion_sequencer_pkg.sv
// motion_pkg: shared encodings for the motion sequencer.
//   - command opcodes (cmd_op)
//   - heading encodings (ori)
//   - FSM state enum
//   - heading rotation helpers turn_left / turn_right
package motion_pkg;

    localparam logic [1:0] OP_FWD   = 2'b00;
    localparam logic [1:0] OP_LEFT  = 2'b01;
    localparam logic [1:0] OP_RIGHT = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    localparam logic [1:0] ORI_PY = 2'b00;
    localparam logic [1:0] ORI_PX = 2'b01;
    localparam logic [1:0] ORI_NX = 2'b10;
    localparam logic [1:0] ORI_NY = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_TURN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Clockwise: +Y -> +X -> -Y -> -X -> +Y
    function automatic logic [1:0] turn_right(input logic [1:0] o);
        case (o)
            ORI_PY:  return ORI_PX;
            ORI_PX:  return ORI_NY;
            ORI_NY:  return ORI_NX;
            default: return ORI_PY;
        endcase
    endfunction

    // Counter-clockwise: +Y -> -X -> -Y -> +X -> +Y
    function automatic logic [1:0] turn_left(input logic [1:0] o);
        case (o)
            ORI_PY:  return ORI_NX;
            ORI_NX:  return ORI_NY;
            ORI_NY:  return ORI_PX;
            default: return ORI_PY;
        endcase
    endfunction

endpackage

// File: rtl/motion_sequencer_tick_sync.sv
// tick_sync: brings the asynchronous encoder pulse into the clk domain
// through two flops and emits a registered one-cycle pulse on each rising
// edge. A tick edge shows up on tick_evt_o three clk cycles later.
//   clk, rst    : clock, synchronous active-high reset
//   tick_i      : raw encoder pulse (asynchronous)
//   tick_evt_o  : one-cycle rising-edge event
module tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    output logic tick_evt_o
);

    logic sync1_q, sync2_q, prev_q, evt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            sync1_q <= tick_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            evt_q   <= sync2_q & ~prev_q;
        end
    end

    assign tick_evt_o = evt_q;

endmodule

// File: rtl/motion_sequencer.sv
// motion_sequencer: command-driven drive/steer sequencer with encoder-based
// step closure, heading and saturating decimetre-grid position tracking,
// and a sticky no-tick watchdog.
//   clk, rst              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE, no fault)
//   cmd_op, cmd_arg       : opcode and FWD distance in dm
//   abort                 : abandon the running FWD/TURN command
//   tick                  : raw encoder pulse (asynchronous)
//   drive_en, turning     : motor / steering enables
//   turn_dir              : 0 left, 1 right (valid while turning)
//   ori, pos_x, pos_y     : heading and grid position
//   done                  : one-cycle completion/abort pulse
//   fault                 : sticky watchdog fault
module motion_sequencer
    import motion_pkg::*;
#(
    parameter int TICKS_PER_DM   = 10,
    parameter int TICKS_PER_TURN = 24,
    parameter int POS_W          = 16,
    parameter int WDOG_CYC       = 50_000_000,
    parameter int X0             = 0,
    parameter int Y0             = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_arg,
    input  logic             abort,
    input  logic             tick,
    output logic             drive_en,
    output logic             turning,
    output logic             turn_dir,
    output logic [1:0]       ori,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             done,
    output logic             fault
);

    localparam int CNT_MAX = (TICKS_PER_DM > TICKS_PER_TURN) ? TICKS_PER_DM : TICKS_PER_TURN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WD_W    = $clog2(WDOG_CYC + 1);

    logic tick_evt;

    tick_sync u_tick_sync (
        .clk        (clk),
        .rst        (rst),
        .tick_i     (tick),
        .tick_evt_o (tick_evt)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [7:0]       rem_q, rem_d;
    logic [1:0]       ori_q, ori_d;
    logic [POS_W-1:0] px_q, px_d, py_q, py_d;
    logic [POS_W-1:0] step_x, step_y;
    logic             ready_q, ready_d;
    logic             drive_q, drive_d;
    logic             turn_q, turn_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;

    // Position one dm ahead along the current heading, clamped at both ends.
    always_comb begin
        step_x = px_q;
        step_y = py_q;
        case (ori_q)
            ORI_PY:  if (py_q != '1) step_y = py_q + 1'b1;
            ORI_NY:  if (py_q != '0) step_y = py_q - 1'b1;
            ORI_PX:  if (px_q != '1) step_x = px_q + 1'b1;
            default: if (px_q != '0) step_x = px_q - 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        wdog_d  = wdog_q;
        rem_d   = rem_q;
        ori_d   = ori_q;
        px_d    = px_q;
        py_d    = py_q;
        ready_d = ready_q;
        drive_d = drive_q;
        turn_d  = turn_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        fault_d = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    ready_d = 1'b0;
                    tcnt_d  = '0;
                    wdog_d  = '0;
                    rem_d   = cmd_arg;
                    case (cmd_op)
                        OP_FWD: begin
                            if (cmd_arg != 8'd0) begin
                                state_d = ST_FWD;
                                drive_d = 1'b1;
                            end else begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end
                        OP_LEFT, OP_RIGHT: begin
                            state_d = ST_TURN;
                            turn_d  = 1'b1;
                            dir_d   = (cmd_op == OP_RIGHT);
                        end
                        default: begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end

            // abort has priority over a same-cycle tick_evt
            ST_FWD: begin
                if (abort) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    drive_d = 1'b0;
                    tcnt_d  = '0;
                end else if (tick_evt) begin
                    wdog_d = '0;
                    if (tcnt_q == CNT_W'(TICKS_PER_DM - 1)) begin
                        tcnt_d = '0;
                        px_d   = step_x;
                        py_d   = step_y;
                        rem_d  = rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            drive_d = 1'b0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end else if (wdog_q == WD_W'(WDOG_CYC - 1)) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    drive_d = 1'b0;
                    tcnt_d  = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            ST_TURN: begin
                if (abort) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    turn_d  = 1'b0;
                    tcnt_d  = '0;
                end else if (tick_evt) begin
                    wdog_d = '0;
                    if (tcnt_q == CNT_W'(TICKS_PER_TURN - 1)) begin
                        tcnt_d  = '0;
                        ori_d   = dir_q ? turn_right(ori_q) : turn_left(ori_q);
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        turn_d  = 1'b0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end else if (wdog_q == WD_W'(WDOG_CYC - 1)) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    turn_d  = 1'b0;
                    tcnt_d  = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tcnt_d  = '0;
                ready_d = ~fault_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            wdog_q  <= '0;
            rem_q   <= '0;
            ori_q   <= ORI_PY;
            px_q    <= POS_W'(X0);
            py_q    <= POS_W'(Y0);
            ready_q <= 1'b1;
            drive_q <= 1'b0;
            turn_q  <= 1'b0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            wdog_q  <= wdog_d;
            rem_q   <= rem_d;
            ori_q   <= ori_d;
            px_q    <= px_d;
            py_q    <= py_d;
            ready_q <= ready_d;
            drive_q <= drive_d;
            turn_q  <= turn_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign cmd_ready = ready_q;
    assign drive_en  = drive_q;
    assign turning   = turn_q;
    assign turn_dir  = dir_q;
    assign ori       = ori_q;
    assign pos_x     = px_q;
    assign pos_y     = py_q;
    assign done      = done_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Bench for motion_sequencer. Two instances share every input: A is a
// 16-bit-position unit starting at (0,38), B a 4-bit-position unit starting
// at (14,0) so both saturation limits are reachable. Expected heading and
// position come from a heading-index/clamp model kept here.
module tb_motion_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [7:0]  cmd_arg = 8'd0;
    logic        abort = 1'b0;
    logic        tick = 1'b0;

    logic        cmd_ready_a, drive_en_a, turning_a, turn_dir_a, done_a, fault_a;
    logic [1:0]  ori_a;
    logic [15:0] pos_x_a, pos_y_a;
    logic        cmd_ready_b, drive_en_b, turning_b, turn_dir_b, done_b, fault_b;
    logic [1:0]  ori_b;
    logic [3:0]  pos_x_b, pos_y_b;

    always #5 clk = ~clk;

    motion_sequencer #(.TICKS_PER_DM(10), .TICKS_PER_TURN(24), .POS_W(16),
                       .WDOG_CYC(100), .X0(0), .Y0(38)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .tick(tick),
        .drive_en(drive_en_a), .turning(turning_a), .turn_dir(turn_dir_a),
        .ori(ori_a), .pos_x(pos_x_a), .pos_y(pos_y_a), .done(done_a), .fault(fault_a)
    );

    motion_sequencer #(.TICKS_PER_DM(10), .TICKS_PER_TURN(24), .POS_W(4),
                       .WDOG_CYC(100), .X0(14), .Y0(0)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .tick(tick),
        .drive_en(drive_en_b), .turning(turning_b), .turn_dir(turn_dir_b),
        .ori(ori_b), .pos_x(pos_x_b), .pos_y(pos_y_b), .done(done_b), .fault(fault_b)
    );

    int total = 0;
    int bad   = 0;
    int ndone_a = 0;
    int ndone_b = 0;

    always @(posedge clk) begin
        if (done_a) ndone_a <= ndone_a + 1;
        if (done_b) ndone_b <= ndone_b + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: heading as a clockwise index 0:+Y 1:+X 2:-Y 3:-X.
    int m_hd;
    int mx[2];
    int my[2];
    int mmax[2];

    function automatic logic [1:0] ori_code(input int hd);
        case (hd)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_reset();
        m_hd = 0;
        mx[0] = 0;  my[0] = 38; mmax[0] = 65535;
        mx[1] = 14; my[1] = 0;  mmax[1] = 15;
    endtask

    task automatic model_steps(input int n);
        for (int s = 0; s < n; s++) begin
            for (int k = 0; k < 2; k++) begin
                case (m_hd)
                    0: my[k] = (my[k] < mmax[k]) ? my[k] + 1 : my[k];
                    1: mx[k] = (mx[k] < mmax[k]) ? mx[k] + 1 : mx[k];
                    2: my[k] = (my[k] > 0) ? my[k] - 1 : 0;
                    default: mx[k] = (mx[k] > 0) ? mx[k] - 1 : 0;
                endcase
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_ori_a"}, ori_a, ori_code(m_hd));
        check({tag, "_ori_b"}, ori_b, ori_code(m_hd));
        check({tag, "_x_a"}, pos_x_a, mx[0]);
        check({tag, "_y_a"}, pos_y_a, my[0]);
        check({tag, "_x_b"}, pos_x_b, mx[1]);
        check({tag, "_y_b"}, pos_y_b, my[1]);
    endtask

    task automatic pulse_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(negedge clk);
            @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    // Offer a command at a negedge; returns at the negedge after the accept edge.
    task automatic send(input string tag, input logic [1:0] op, input logic [7:0] arg);
        logic is_turn;
        check({tag, "_ready_pre"}, cmd_ready_a, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
        is_turn = (op == 2'b01) || (op == 2'b10);
        check({tag, "_drive_rise"}, drive_en_a, (op == 2'b00) && (arg != 8'd0));
        check({tag, "_turn_rise"}, turning_a, is_turn);
        check({tag, "_done_imm"}, done_a, (op == 2'b11) || ((op == 2'b00) && (arg == 8'd0)));
        check({tag, "_ready_low"}, cmd_ready_a, 1'b0);
        if (is_turn) check({tag, "_dir"}, turn_dir_a, op == 2'b10);
    endtask

    // Wait (bounded) for done, then check completion-cycle outputs.
    task automatic wait_done(input string tag, input int d0);
        int i = 0;
        while (!done_a && i < 400) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_done_seen"}, done_a, 1'b1);
        check({tag, "_done_b"}, done_b, 1'b1);
        check({tag, "_drive_fall"}, drive_en_a, 1'b0);
        check({tag, "_turn_fall"}, turning_a, 1'b0);
        check({tag, "_ready_at_done"}, cmd_ready_a, 1'b0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done_a, 1'b0);
        check({tag, "_ready_back"}, cmd_ready_a, 1'b1);
        check({tag, "_done_count"}, ndone_a - d0, 1);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] arg,
                           input int nt, input bit ab);
        int d0 = ndone_a;
        int steps;
        send(tag, op, arg);
        pulse_ticks(nt);
        if (ab) begin
            @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        wait_done(tag, d0);
        if (op == 2'b00) begin
            steps = nt / 10;
            if (steps > int'(arg)) steps = int'(arg);
            model_steps(steps);
        end else if (op == 2'b01 && nt >= 24) begin
            m_hd = (m_hd + 3) % 4;
        end else if (op == 2'b10 && nt >= 24) begin
            m_hd = (m_hd + 1) % 4;
        end
        compare_model(tag);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] arg;
        int         nt;
        bit         ab;
        logic [1:0] e_ori;
        int         e_x;
        int         e_y;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int d0;
        int i;
        tbl[0] = '{2'b00, 8'd3, 30, 1'b0, 2'b00, 0, 41};
        tbl[1] = '{2'b10, 8'd0, 24, 1'b0, 2'b01, 0, 41};
        tbl[2] = '{2'b00, 8'd2, 20, 1'b0, 2'b01, 2, 41};
        tbl[3] = '{2'b01, 8'd0, 24, 1'b0, 2'b00, 2, 41};
        tbl[4] = '{2'b01, 8'd0, 24, 1'b0, 2'b10, 2, 41};
        tbl[5] = '{2'b00, 8'd5, 27, 1'b1, 2'b10, 0, 41};
        tbl[6] = '{2'b11, 8'd7, 0,  1'b0, 2'b10, 0, 41};
        tbl[7] = '{2'b00, 8'd0, 0,  1'b0, 2'b10, 0, 41};
        tbl[8] = '{2'b01, 8'd0, 24, 1'b0, 2'b11, 0, 41};
        tbl[9] = '{2'b00, 8'd5, 50, 1'b0, 2'b11, 0, 36};

        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", cmd_ready_a, 1'b1);
        check("rst_drive", drive_en_a, 1'b0);
        check("rst_turning", turning_a, 1'b0);
        check("rst_dir", turn_dir_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_fault", fault_a, 1'b0);
        compare_model("rst");

        for (int v = 0; v < 10; v++) begin
            run_cmd($sformatf("vec%0d", v), tbl[v].op, tbl[v].arg, tbl[v].nt, tbl[v].ab);
            check($sformatf("vec%0d_tbl_ori", v), ori_a, tbl[v].e_ori);
            check($sformatf("vec%0d_tbl_x", v), pos_x_a, tbl[v].e_x);
            check($sformatf("vec%0d_tbl_y", v), pos_y_a, tbl[v].e_y);
        end

        // abort while idle is ignored
        d0 = ndone_a;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_abort_no_done", ndone_a - d0, 0);
        check("idle_abort_ready", cmd_ready_a, 1'b1);

        // nine ticks are not enough for one dm; the tenth completes it
        d0 = ndone_a;
        send("partial", 2'b00, 8'd1);
        pulse_ticks(9);
        repeat (6) @(negedge clk);
        check("partial_still_driving", drive_en_a, 1'b1);
        check("partial_no_done", ndone_a - d0, 0);
        check("partial_y_held", pos_y_a, my[0]);
        pulse_ticks(1);
        wait_done("partial", d0);
        model_steps(1);
        compare_model("partial");
        check("partial_tbl_y", pos_y_a, 35);

        // abort lands on the same cycle as the tenth tick_evt
        d0 = ndone_a;
        send("coinc", 2'b00, 8'd1);
        pulse_ticks(9);
        tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("coinc", d0);
        compare_model("coinc");
        check("coinc_tbl_y", pos_y_a, 35);

        // watchdog: FWD with no ticks
        d0 = ndone_a;
        send("wdog", 2'b00, 8'd1);
        i = 0;
        while (!fault_a && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("wdog_cycle", i, 100);
        check("wdog_fault_b", fault_b, 1'b1);
        check("wdog_done", done_a, 1'b1);
        check("wdog_drive_off", drive_en_a, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_arg   = 8'd1;
        repeat (20) @(negedge clk);
        cmd_valid = 1'b0;
        check("wdog_ready_stuck", cmd_ready_a, 1'b0);
        check("wdog_no_restart", drive_en_a, 1'b0);
        check("wdog_fault_sticky", fault_a, 1'b1);
        check("wdog_one_done", ndone_a - d0, 1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        check("rst2_fault", fault_a, 1'b0);
        check("rst2_ready", cmd_ready_a, 1'b1);
        compare_model("rst2");

        // randomized commands against the model
        for (int r = 0; r < 40; r++) begin
            logic [1:0] op;
            logic [7:0] arg;
            int need, nt;
            bit ab;
            op  = 2'($urandom_range(0, 3));
            arg = 8'($urandom_range(0, 3));
            need = (op == 2'b00) ? int'(arg) * 10 : ((op == 2'b11) ? 0 : 24);
            ab = (need > 0) && ($urandom_range(0, 3) == 0);
            nt = ab ? int'($urandom_range(0, need - 1)) : need;
            run_cmd($sformatf("rnd%0d", r), op, arg, nt, ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
